// File: rtl/switch_pkg.sv
// Shared types and sizing helpers for the buffered core-to-core switch.
// Elements are IEEE-754 single-precision values carried as raw 32-bit patterns.
package switch_pkg;
   localparam int ELEM_W    = 32;
   localparam int DEF_WIDTH = 2;
   localparam int DEF_DEPTH = 4;

   typedef logic [ELEM_W-1:0] elem_t;
   typedef elem_t [DEF_WIDTH-1:0] vector_t;

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction
endpackage

// File: rtl/switch_fifo.sv
// One (src,dst) queue: DEPTH entries, head visible combinationally, no bypass.
// Push into full and pop from empty are ignored; full/empty reflect pre-edge occupancy.
module switch_fifo
   import switch_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  elem_t [WIDTH-1:0]  push_dat_i,
   input  logic               pop_i,
   output logic               full_o,
   output logic               empty_o,
   output elem_t [WIDTH-1:0]  head_o
);
   localparam int CW = cnt_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);

   elem_t [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              do_push, do_pop;

   function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_comb begin
      wr_ptr_d = do_push ? wrap_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? wrap_inc(rd_ptr_q) : rd_ptr_q;
      cnt_d    = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
      end
   end
endmodule

// File: rtl/buffered_switch.sv
// Core-to-core switch with a private FIFO per (src,dst) pair; unicast or all-or-nothing broadcast.
// send_ok is combinational from send_* and full flags; recv outputs are registered one cycle after a pop.
module buffered_switch
   import switch_pkg::*;
#(
   parameter int WIDTH          = DEF_WIDTH,
   parameter int CORE_SIZE      = 3,
   parameter int DEPTH          = DEF_DEPTH,
   parameter int CORE_ADDR_SIZE = (CORE_SIZE > 1) ? $clog2(CORE_SIZE) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      send_ready     [CORE_SIZE-1:0],
   input  logic                      send_broadcast [CORE_SIZE-1:0],
   input  logic [CORE_ADDR_SIZE-1:0] send_core_idx  [CORE_SIZE-1:0],
   input  elem_t [WIDTH-1:0]         send_data      [CORE_SIZE-1:0],
   output logic                      send_ok        [CORE_SIZE-1:0],
   input  logic                      recv_request   [CORE_SIZE-1:0],
   input  logic [CORE_ADDR_SIZE-1:0] recv_core_idx  [CORE_SIZE-1:0],
   output logic                      recv_ready     [CORE_SIZE-1:0],
   output elem_t [WIDTH-1:0]         recv_data      [CORE_SIZE-1:0]
);
   logic              push  [CORE_SIZE][CORE_SIZE];
   logic              pop   [CORE_SIZE][CORE_SIZE];
   logic              full  [CORE_SIZE][CORE_SIZE];
   logic              empty [CORE_SIZE][CORE_SIZE];
   elem_t [WIDTH-1:0] head  [CORE_SIZE][CORE_SIZE];

   logic              bc_ok      [CORE_SIZE];
   logic              uc_ok      [CORE_SIZE];
   logic              recv_hit   [CORE_SIZE];
   elem_t [WIDTH-1:0] recv_sel   [CORE_SIZE];
   logic              recv_ready_q [CORE_SIZE-1:0];
   logic              recv_ready_d [CORE_SIZE-1:0];
   elem_t [WIDTH-1:0] recv_data_q  [CORE_SIZE-1:0];
   elem_t [WIDTH-1:0] recv_data_d  [CORE_SIZE-1:0];

   for (genvar s = 0; s < CORE_SIZE; s++) begin : g_src
      for (genvar d = 0; d < CORE_SIZE; d++) begin : g_dst
         switch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk        (clock),
            .rst        (reset),
            .push_i     (push[s][d]),
            .push_dat_i (send_data[s]),
            .pop_i      (pop[s][d]),
            .full_o     (full[s][d]),
            .empty_o    (empty[s][d]),
            .head_o     (head[s][d])
         );
      end
   end

   // An out-of-range unicast index matches no FIFO, so it is never accepted.
   always_comb begin
      for (int i = 0; i < CORE_SIZE; i++) begin
         bc_ok[i] = 1'b1;
         uc_ok[i] = 1'b0;
         for (int d = 0; d < CORE_SIZE; d++) begin
            if (d != i && full[i][d]) bc_ok[i] = 1'b0;
            if (send_core_idx[i] == CORE_ADDR_SIZE'(d) && !full[i][d]) uc_ok[i] = 1'b1;
         end
         send_ok[i] = send_ready[i] && (send_broadcast[i] ? bc_ok[i] : uc_ok[i]);
         for (int d = 0; d < CORE_SIZE; d++) begin
            push[i][d] = send_ok[i] &&
                         (send_broadcast[i] ? (d != i)
                                            : (send_core_idx[i] == CORE_ADDR_SIZE'(d)));
         end
      end
   end

   always_comb begin
      for (int j = 0; j < CORE_SIZE; j++) begin
         recv_hit[j] = 1'b0;
         recv_sel[j] = '0;
         for (int s = 0; s < CORE_SIZE; s++) begin
            pop[s][j] = recv_request[j] && (recv_core_idx[j] == CORE_ADDR_SIZE'(s)) && !empty[s][j];
            if (pop[s][j]) begin
               recv_hit[j] = 1'b1;
               recv_sel[j] = head[s][j];
            end
         end
         recv_ready_d[j] = recv_hit[j];
         recv_data_d[j]  = recv_hit[j] ? recv_sel[j] : recv_data_q[j];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int j = 0; j < CORE_SIZE; j++) begin
            recv_ready_q[j] <= 1'b0;
            recv_data_q[j]  <= '0;
         end
      end else begin
         for (int j = 0; j < CORE_SIZE; j++) begin
            recv_ready_q[j] <= recv_ready_d[j];
            recv_data_q[j]  <= recv_data_d[j];
         end
      end
   end

   assign recv_ready = recv_ready_q;
   assign recv_data  = recv_data_q;
endmodule

// File: tb/tb_buffered_switch.sv
// Directed bench for buffered_switch at WIDTH=2, CORE_SIZE=3, DEPTH=2.
// Vector values are single-precision bit patterns, element 0 in the low word.
module tb_buffered_switch;
   import switch_pkg::*;

   localparam int W  = 2;
   localparam int CS = 3;
   localparam int DP = 2;
   localparam int AW = 2;

   localparam logic [31:0] F0  = 32'h0000_0000;
   localparam logic [31:0] F1  = 32'h3F80_0000;
   localparam logic [31:0] F2  = 32'h4000_0000;
   localparam logic [31:0] F3  = 32'h4040_0000;
   localparam logic [31:0] F5  = 32'h40A0_0000;
   localparam logic [31:0] F7  = 32'h40E0_0000;
   localparam logic [31:0] F11 = 32'h4130_0000;
   localparam logic [31:0] F13 = 32'h4150_0000;

   logic              clock = 1'b0;
   logic              reset;
   logic              send_ready     [CS-1:0];
   logic              send_broadcast [CS-1:0];
   logic [AW-1:0]     send_core_idx  [CS-1:0];
   elem_t [W-1:0]     send_data      [CS-1:0];
   logic              send_ok        [CS-1:0];
   logic              recv_request   [CS-1:0];
   logic [AW-1:0]     recv_core_idx  [CS-1:0];
   logic              recv_ready     [CS-1:0];
   elem_t [W-1:0]     recv_data      [CS-1:0];

   int vectors = 0;
   int errs    = 0;

   buffered_switch #(.WIDTH(W), .CORE_SIZE(CS), .DEPTH(DP)) dut (
      .clock          (clock),
      .reset          (reset),
      .send_ready     (send_ready),
      .send_broadcast (send_broadcast),
      .send_core_idx  (send_core_idx),
      .send_data      (send_data),
      .send_ok        (send_ok),
      .recv_request   (recv_request),
      .recv_core_idx  (recv_core_idx),
      .recv_ready     (recv_ready),
      .recv_data      (recv_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] vec(input logic [31:0] e0, input logic [31:0] e1);
      return {e1, e0};
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      for (int i = 0; i < CS; i++) begin
         send_ready[i]     = 1'b0;
         send_broadcast[i] = 1'b0;
         send_core_idx[i]  = '0;
         send_data[i]      = '0;
         recv_request[i]   = 1'b0;
         recv_core_idx[i]  = '0;
      end
   endtask

   task automatic offer(input int src, input int dst, input logic bc,
                        input logic [31:0] e0, input logic [31:0] e1);
      send_ready[src]     = 1'b1;
      send_broadcast[src] = bc;
      send_core_idx[src]  = AW'(dst);
      send_data[src]      = {e1, e0};
   endtask

   task automatic req(input int dst, input int src);
      recv_request[dst]  = 1'b1;
      recv_core_idx[dst] = AW'(src);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      repeat (2) step();
      for (int j = 0; j < CS; j++) begin
         check("rst_ready", 64'(recv_ready[j]), 64'd0);
         check("rst_data", 64'(recv_data[j]), 64'd0);
      end
      reset = 1'b0;
      step();

      // unicast core2 -> core1
      offer(2, 1, 1'b0, F11, F13);
      #1 check("uni_send_ok", 64'(send_ok[2]), 64'd1);
      step();
      idle();
      repeat (3) step();
      req(1, 2);
      step();
      check("uni_ready", 64'(recv_ready[1]), 64'd1);
      check("uni_data", 64'(recv_data[1]), vec(F11, F13));
      step();
      check("uni_again_ready", 64'(recv_ready[1]), 64'd0);
      check("uni_hold_data", 64'(recv_data[1]), vec(F11, F13));
      idle();

      // fill core0 -> core2, third offer backpressured
      offer(0, 2, 1'b0, F1, F1);
      #1 check("full_ok1", 64'(send_ok[0]), 64'd1);
      step();
      offer(0, 2, 1'b0, F2, F2);
      #1 check("full_ok2", 64'(send_ok[0]), 64'd1);
      step();
      offer(0, 2, 1'b0, F3, F3);
      #1 check("full_ok3", 64'(send_ok[0]), 64'd0);
      req(2, 0);
      #1 check("full_pop_same_cycle_ok", 64'(send_ok[0]), 64'd0);
      step();
      check("full_pop1_ready", 64'(recv_ready[2]), 64'd1);
      check("full_pop1_data", 64'(recv_data[2]), vec(F1, F1));
      recv_request[2] = 1'b0;
      #1 check("full_ok3_retry", 64'(send_ok[0]), 64'd1);
      step();
      idle();
      req(2, 0);
      step();
      check("full_pop2_data", 64'(recv_data[2]), vec(F2, F2));
      step();
      check("full_pop3_ready", 64'(recv_ready[2]), 64'd1);
      check("full_pop3_data", 64'(recv_data[2]), vec(F3, F3));
      step();
      check("full_drained", 64'(recv_ready[2]), 64'd0);
      idle();

      // broadcast from core1; send_core_idx must be ignored
      offer(1, 3, 1'b1, F5, F7);
      #1 check("bc_ok", 64'(send_ok[1]), 64'd1);
      step();
      idle();
      req(0, 1);
      req(1, 1);
      req(2, 1);
      step();
      check("bc_c0_ready", 64'(recv_ready[0]), 64'd1);
      check("bc_c0_data", 64'(recv_data[0]), vec(F5, F7));
      check("bc_c2_ready", 64'(recv_ready[2]), 64'd1);
      check("bc_c2_data", 64'(recv_data[2]), vec(F5, F7));
      check("bc_self_ready", 64'(recv_ready[1]), 64'd0);
      idle();

      // broadcast blocked by one full target, nothing pushed anywhere
      offer(1, 2, 1'b0, F1, F1);
      step();
      offer(1, 2, 1'b0, F2, F2);
      step();
      offer(1, 0, 1'b1, F5, F7);
      #1 check("bc_blocked_ok", 64'(send_ok[1]), 64'd0);
      step();
      idle();
      req(0, 1);
      req(2, 1);
      step();
      check("bc_blocked_c0", 64'(recv_ready[0]), 64'd0);
      check("bc_blocked_c2_data", 64'(recv_data[2]), vec(F1, F1));
      step();
      check("bc_blocked_c0_again", 64'(recv_ready[0]), 64'd0);
      check("bc_blocked_c2_data2", 64'(recv_data[2]), vec(F2, F2));
      idle();

      // push and pop an empty FIFO in the same cycle
      offer(0, 1, 1'b0, F3, F3);
      req(1, 0);
      #1 check("empty_same_ok", 64'(send_ok[0]), 64'd1);
      step();
      check("empty_same_ready", 64'(recv_ready[1]), 64'd0);
      send_ready[0] = 1'b0;
      step();
      check("empty_retry_ready", 64'(recv_ready[1]), 64'd1);
      check("empty_retry_data", 64'(recv_data[1]), vec(F3, F3));
      idle();

      // out-of-range indices
      offer(0, 3, 1'b0, F7, F7);
      req(0, 3);
      #1 check("bad_send_idx", 64'(send_ok[0]), 64'd0);
      step();
      check("bad_recv_idx", 64'(recv_ready[0]), 64'd0);
      idle();

      // asynchronous reset with data in flight
      offer(2, 0, 1'b0, F11, F13);
      step();
      offer(2, 0, 1'b0, F5, F7);
      step();
      idle();
      req(0, 2);
      step();
      check("pre_rst_ready", 64'(recv_ready[0]), 64'd1);
      check("pre_rst_data", 64'(recv_data[0]), vec(F11, F13));
      idle();
      #2 reset = 1'b1;
      #1;
      check("async_rst_ready", 64'(recv_ready[0]), 64'd0);
      check("async_rst_data", 64'(recv_data[0]), vec(F0, F0));
      #2 reset = 1'b0;
      req(0, 2);
      step();
      check("post_rst_pop1", 64'(recv_ready[0]), 64'd0);
      step();
      check("post_rst_pop2", 64'(recv_ready[0]), 64'd0);
      idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/buffered_switch.md
# buffered_switch

Parametrised, buffered successor to the core-to-core switch. Each sender core pushes a WIDTH-element vector addressed to a destination core, or broadcasts it to all other cores. Each receiver core pulls the oldest vector from a named source core. Every (source, destination) pair has its own DEPTH-entry FIFO, so senders and receivers no longer need to rendezvous in the same cycle, and ordering per pair is preserved.

## Interface
Parameters:
- WIDTH, 2: shortreal elements per vector.
- CORE_SIZE, 3: number of cores (senders = receivers).
- DEPTH, 4: entries per (src,dst) FIFO; ≥1.
- CORE_ADDR_SIZE, $clog2(CORE_SIZE): derived, core index width.

Ports (all per-core arrays are unpacked [CORE_SIZE-1:0]):
- Clocking and reset: one clock, `clock`; reset is asynchronous and active-high, named `reset`.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- send_ready  in  1 per core  sender offers a vector this cycle.
- send_broadcast  in  1 per core  offer goes to every core except the sender; send_core_idx ignored.
- send_core_idx  in  CORE_ADDR_SIZE per core  destination core.
- send_data  in  shortreal[WIDTH] per core  vector offered.
- send_ok  out  1 per core  combinational; offer accepted at this rising edge.
- recv_request  in  1 per core  single-cycle pull request.
- recv_core_idx  in  CORE_ADDR_SIZE per core  source core to pull from.
- recv_ready  out  1 per core  registered; recv_data valid this cycle.
- recv_data  out  shortreal[WIDTH] per core  registered popped vector.

## Operation
- Storage is fifo[src][dst], CORE_SIZE×CORE_SIZE, each DEPTH deep. Self-send (src == dst) is legal.
- Unicast send_ok[i] = send_ready[i] && send_core_idx[i] < CORE_SIZE && !full(fifo[i][idx]).
- Broadcast send_ok[i] = send_ready[i] && every fifo[i][d] with d≠i is not full. All-or-nothing: either every target is pushed or none is.
- Push happens at the rising edge where send_ok is 1. The sender holds send_ready/data until it sees send_ok; it may withdraw the offer at any time.
- A pop happens at the edge where recv_request[j] is 1, recv_core_idx[j] < CORE_SIZE and fifo[idx][j] is non-empty. The next cycle has recv_ready[j]=1 and recv_data[j]=the head entry.
  - If any condition fails: no pop, recv_ready[j]=0, recv_data[j] holds its last value.
  - A request is not queued. The receiver must re-issue it.
- Full/empty decisions use occupancy before the edge. There is no bypass:
  - Push into a full FIFO is refused even if it is popped in the same cycle.
  - Pop from an empty FIFO fails even if it is pushed in the same cycle.
- A simultaneous push and pop on a non-empty, non-full FIFO both occur, and occupancy is unchanged.
- Pointers wrap modulo DEPTH. Occupancy counters are $clog2(DEPTH+1) bits wide.
- Reset (any time, including mid-transfer):
  - All FIFOs empty, pointers and counts 0.
  - recv_ready 0 and recv_data 0.0.
  - In-flight data is discarded.

## Timing
- Send-to-recv latency is at least 2 cycles: push at edge N, earliest pop at edge N+1, data visible in cycle N+1..N+2.
- Throughput is one push and one pop per core per cycle.
- send_ok has a combinational path from send_* and FIFO full flags. There is no path from recv_* to send_ok.
- recv_ready/recv_data are pure flop outputs.

## Structure
- Package switch_pkg holds:
  - typedef vector_t (shortreal [WIDTH-1:0] via parameterised struct or macro);
  - the default DEPTH;
  - a function computing the counter width.
- Sub-module switch_fifo (WIDTH, DEPTH) provides push/pop/full/empty/head, with asynchronous reset. buffered_switch instantiates CORE_SIZE² copies in a generate loop and adds the send arbitration and recv mux/registers.

## Test plan
Parameters for all scenarios: WIDTH=2, CORE_SIZE=3, DEPTH=2.
- Unicast:
  - Stimulus: core2 sends {11,13} to core1; three idle cycles; core1 requests src 2.
  - Response: send_ok[2]=1 in the offer cycle; next cycle recv_ready[1]=1, recv_data[1]={11,13}.
  - A second request returns recv_ready[1]=0.
- Full/backpressure:
  - Stimulus: core0 offers {1,1}, {2,2}, {3,3} to core2.
  - Response: the third offer sees send_ok[0]=0. After core2 pops {1,1}, the third offer is accepted. Pops then yield {2,2}, {3,3} in order.
- Broadcast:
  - Stimulus: core1 broadcasts {5,7}.
  - Response: core0 and core2 each pop {5,7} from src 1; core1 popping src 1 gets recv_ready=0.
  - With fifo[1][2] pre-filled to 2 entries, broadcast send_ok[1]=0 and fifo[1][0] is unchanged.
- Same-cycle edges:
  - Empty FIFO push+pop in one cycle: recv_ready=0; a retry next cycle returns the data.
  - Full FIFO pop+offer in one cycle: send_ok=0.
- Invalid index:
  - send_core_idx=3 gives send_ok=0.
  - recv_core_idx=3 gives recv_ready=0.
- Reset mid-operation:
  - Stimulus: load two entries, assert reset asynchronously between edges.
  - Response: recv_ready drops immediately; recv_data=0.0; after release, all pops fail.
